// File: rtl/data_mem_mover_pkg.sv
// Shared constants for the data memory block mover: word constants, FSM state
// encodings and op codes.
package data_mem_mover_pkg;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    localparam logic [WORD_W-1:0] WORD_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/data_mem_mover.sv
// Block-transfer initiator: copies or fills a run of words on the data memory port.
// Optional running checksum of written words when DATA_MEM_MOVER_CHECKSUM_EN is defined.
module data_mem_mover
    import data_mem_mover_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [WORD_W-1:0] src_addr,
    input  logic [WORD_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [WORD_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
`ifdef DATA_MEM_MOVER_CHECKSUM_EN
    output logic [WORD_W-1:0] checksum,
`endif
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WORD_W-1:0] read_data
);

    state_t             state;
    state_t             next_state;
    logic               op_q;
    logic [WORD_W-1:0]  src_ptr;
    logic [WORD_W-1:0]  dst_ptr;
    logic [LEN_W-1:0]   remaining;
    logic [WORD_W-1:0]  fill_q;
    logic [WORD_W-1:0]  data_buf;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory-side outputs decode from state alone, so an async reset clears them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        address    = WORD_ZERO;
        write_data = WORD_ZERO;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        next_state = DONE;
                    else if (op == OP_FILL)
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                address    = src_ptr;
                mem_read   = 1'b1;
                next_state = WR;
            end
            WR: begin
                busy       = 1'b1;
                address    = dst_ptr;
                mem_write  = 1'b1;
                write_data = (op_q == OP_FILL) ? fill_q : data_buf;
                if (remaining == LEN_W'(1))
                    next_state = DONE;
                else if (op_q == OP_FILL)
                    next_state = WR;
                else
                    next_state = RD;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_COPY;
            src_ptr   <= WORD_ZERO;
            dst_ptr   <= WORD_ZERO;
            remaining <= '0;
            fill_q    <= WORD_ZERO;
            // NOTE: the word buffer is a plain register (not a RAM), so it is reset
            // along with the pointers to keep the post-reset state fully defined.
            data_buf  <= WORD_ZERO;
`ifdef DATA_MEM_MOVER_CHECKSUM_EN
            checksum  <= WORD_ZERO;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        fill_q    <= fill_value;
`ifdef DATA_MEM_MOVER_CHECKSUM_EN
                        checksum  <= WORD_ZERO;
`endif
                    end
                end
                RD: begin
                    data_buf <= read_data;
                    src_ptr  <= src_ptr + WORD_W'(1);
                end
                WR: begin
                    dst_ptr   <= dst_ptr + WORD_W'(1);
                    remaining <= remaining - LEN_W'(1);
`ifdef DATA_MEM_MOVER_CHECKSUM_EN
                    checksum  <= checksum + write_data;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/data_mem_mover.md
# data_mem_mover

Block-transfer initiator driving the data memory port: on a start pulse it copies a run of words from one address range to another, or fills a range with a constant, and reports completion. Sits between the control path and the data memory; its memory-side outputs connect directly to the memory's address, write data, read and write strobes, and its read data input.

## Interface
- No parameters. Word width is 32 bits and length width is 16 bits, both fixed.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = COPY, 1 = FILL
- src_addr  in  32  first source word address (COPY only)
- dst_addr  in  32  first destination word address
- length  in  16  number of words to move; 0 is legal
- fill_value  in  32  word written by FILL
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- address  out  32  memory address
- write_data  out  32  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe (memory captures on posedge clk)
- read_data  in  32  memory read data, combinational from address/mem_read

## Operation
- Reset: all outputs are 0; FSM is IDLE; internal pointers, counter and buffer are 0.
- FSM states:
  - IDLE: at a posedge with start=1, latch op, src_addr, dst_addr, length and fill_value into internal registers. If length=0, go to DONE. Otherwise go to RD for COPY, or WR for FILL.
  - RD (COPY only): address=src_ptr, mem_read=1. At the closing edge, capture read_data into buf, increment src_ptr, go to WR.
  - WR: address=dst_ptr, mem_write=1, write_data = buf (COPY) or fill_value (FILL). At the closing edge, increment dst_ptr and decrement remaining. If the new remaining is 0, go to DONE; else go to RD (COPY) or stay in WR (FILL).
  - DONE: done=1, busy=0. Next state is IDLE.
- Outside RD/WR, address, write_data, mem_read and mem_write are all 0. mem_read and mem_write are never high in the same cycle.
- Address arithmetic:
  - Pointers are 32-bit and wrap modulo 2^32.
  - The memory decodes only address[15:0], so ranges wrap at 65536 words.
  - Overlapping ranges are copied strictly ascending, word by word. No overlap correction is performed.
- start while busy or in DONE is ignored; inputs are not re-sampled.
- Inputs latched at acceptance are held for the whole transfer. Later changes to src_addr, dst_addr, length, op or fill_value have no effect.

## Timing
- Accept edge = edge E.
- COPY of n words:
  - Strobes occupy cycles E+1 … E+2n, alternating RD, WR.
  - done is high in cycle E+2n+1.
  - start can be accepted again at the edge ending that DONE cycle.
- FILL of n words: WR occupies cycles E+1 … E+n; done is high in cycle E+n+1.
- length=0: no strobes; done is high in cycle E+1.
- busy is high exactly during the RD/WR cycles.
- rst_n low mid-transfer:
  - Outputs clear immediately, without waiting for clk, and the FSM returns to IDLE.
  - Words written at earlier edges remain in memory.
  - The in-flight word is not written.

## Configuration
- DATA_MEM_MOVER_CHECKSUM_EN defined:
  - Extra output checksum [31:0] (reset 0).
  - Cleared at start acceptance.
  - At each WR closing edge, checksum += word written (modulo 2^32).
  - Holds its final value from the DONE cycle until the next acceptance.
- Macro undefined: the port and the accumulator are absent. All other behaviour is identical.

## Structure
- Shared constants header (same one already holding WORD_ZERO) gains:
  - FSM state encodings IDLE/RD/WR/DONE
  - op codes OP_COPY = 1'b0, OP_FILL = 1'b1
- Single module data_mem_mover; no sub-module.
- The bench instantiates the existing data memory as the responder.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. Release, no start → stays idle, no strobes.
- COPY src=2, dst=100, length=3 with mem[2..4]=A,B,C:
  - mem[100..102]=A,B,C.
  - done pulses in cycle E+7, exactly 6 strobe cycles.
  - checksum=A+B+C when DATA_MEM_MOVER_CHECKSUM_EN is defined.
- FILL dst=0xFFFE, length=4, fill_value=0xFFFF0000:
  - addresses 0xFFFE, 0xFFFF, 0x10000, 0x10001 are driven.
  - mem[65534], mem[65535], mem[0], mem[1] are written.
  - done in cycle E+5.
- length=0 COPY → no mem_read/mem_write ever high; done in cycle E+1.
- Assert start again in every busy cycle and change src_addr mid-transfer → single transfer completes with the original parameters; exactly one done.
- Pull rst_n low in the second WR of a 5-word FILL at dst=10:
  - mem[10] is written, mem[11] is not.
  - Outputs are 0 immediately.
  - A new FILL after release works normally.
